// File: rtl/i2s_clock_ctrl.sv
// I2S bus-clock master and frame sequencer.
// Generates sck/ws from ACLK, issues bit/frame timing strobes, and only
// starts or stops the bus on frame boundaries so no partial frame is seen.
module i2s_clock_ctrl #(
    parameter int SCK_DIV   = 8,
    parameter int SLOT_BITS = 32,
    parameter int FCNT_W    = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic                           enable,
    output logic                           sck,
    output logic                           ws,
    output logic                           sck_rise,
    output logic                           sck_fall,
    output logic                           frame_start,
    output logic [$clog2(2*SLOT_BITS)-1:0] bit_index,
    output logic [FCNT_W-1:0]              frame_count,
    output logic                           running
);

    localparam int DIV_W = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
    localparam int BIT_W = $clog2(2*SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2*SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_nxt;
    logic [BIT_W-1:0]   bit_nxt;
    logic [FCNT_W-1:0]  fcnt_nxt;
    logic               end_of_frame;
    logic               active_nxt;
    logic               sck_nxt;
    logic               ws_nxt;
    logic               rise_nxt;
    logic               fall_nxt;
    logic               fstart_nxt;

    // Next-state, next-counter and next-output logic; outputs are computed
    // from the next counter values so the registered strobes line up with
    // the counters they describe.
    always_comb begin
        state_nxt    = state;
        div_nxt      = div_cnt;
        bit_nxt      = bit_index;
        fcnt_nxt     = frame_count;
        end_of_frame = (state != IDLE) && (div_cnt == DIV_LAST) && (bit_index == BIT_LAST);

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_nxt = RUN;
                end else if (end_of_frame) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state != IDLE) begin
            if (div_cnt == DIV_LAST) begin
                div_nxt = '0;
                if (bit_index == BIT_LAST) begin
                    bit_nxt = '0;
                end else begin
                    bit_nxt = bit_index + 1'b1;
                end
            end else begin
                div_nxt = div_cnt + 1'b1;
            end
        end

        if (end_of_frame) begin
            fcnt_nxt = frame_count + 1'b1;
        end

        if (state_nxt == IDLE) begin
            div_nxt = '0;
            bit_nxt = '0;
        end

        active_nxt = (state_nxt != IDLE);
        sck_nxt    = active_nxt && (div_nxt >= DIV_HALF);
        ws_nxt     = active_nxt && (bit_nxt >= SLOT_LEN);
        rise_nxt   = active_nxt && (div_nxt == DIV_HALF);
        fall_nxt   = active_nxt && (div_nxt == '0) && (state != IDLE);
        fstart_nxt = active_nxt && (div_nxt == '0) && (bit_nxt == '0);
    end

    // State, counters and registered bus outputs with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_index   <= '0;
            frame_count <= '0;
            sck         <= 1'b0;
            ws          <= 1'b0;
            sck_rise    <= 1'b0;
            sck_fall    <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_nxt;
            div_cnt     <= div_nxt;
            bit_index   <= bit_nxt;
            frame_count <= fcnt_nxt;
            sck         <= sck_nxt;
            ws          <= ws_nxt;
            sck_rise    <= rise_nxt;
            sck_fall    <= fall_nxt;
            frame_start <= fstart_nxt;
            running     <= active_nxt;
        end
    end

endmodule

// File: tb/tb_i2s_clock_ctrl.sv
// Self-checking bench for i2s_clock_ctrl: a default-parameter instance and a
// minimum-divider instance, each compared every cycle against a cycle-count
// based reference model, plus directed scenario tasks.
module tb_i2s_clock_ctrl;

    localparam int DIV1 = 8;
    localparam int SLOT1 = 32;
    localparam int FW1 = 16;
    localparam int DIV2 = 2;
    localparam int SLOT2 = 4;
    localparam int FW2 = 2;
    localparam int FRAME1 = DIV1 * 2 * SLOT1;

    logic clk = 1'b0;
    logic rstn;
    logic en1;
    logic en2;

    logic sck1, ws1, rise1, fall1, fs1, run1;
    logic [$clog2(2*SLOT1)-1:0] bidx1;
    logic [FW1-1:0] fc1;
    logic sck2, ws2, rise2, fall2, fs2, run2;
    logic [$clog2(2*SLOT2)-1:0] bidx2;
    logic [FW2-1:0] fc2;

    int n_checks = 0;
    int n_fail = 0;

    always #10 clk = ~clk;

    i2s_clock_ctrl #(.SCK_DIV(DIV1), .SLOT_BITS(SLOT1), .FCNT_W(FW1)) dut1 (
        .ACLK(clk), .ARESETN(rstn), .enable(en1),
        .sck(sck1), .ws(ws1), .sck_rise(rise1), .sck_fall(fall1),
        .frame_start(fs1), .bit_index(bidx1), .frame_count(fc1), .running(run1)
    );

    i2s_clock_ctrl #(.SCK_DIV(DIV2), .SLOT_BITS(SLOT2), .FCNT_W(FW2)) dut2 (
        .ACLK(clk), .ARESETN(rstn), .enable(en2),
        .sck(sck2), .ws(ws2), .sck_rise(rise2), .sck_fall(fall2),
        .frame_start(fs2), .bit_index(bidx2), .frame_count(fc2), .running(run2)
    );

    // Reference model: bus position is a plain cycle count since the bus
    // started; everything else is derived arithmetically from it.
    typedef struct {
        bit active;
        bit pend;
        bit first;
        int t;
        int fc;
    } model_t;

    typedef struct packed {
        logic       sck;
        logic       ws;
        logic       rise;
        logic       fall;
        logic       fs;
        logic       run;
        logic [7:0] bidx;
        logic [15:0] fc;
    } obs_t;

    model_t m1;
    model_t m2;

    function automatic model_t model_step(model_t m, logic rst_n, logic en, int div, int slot, int fw);
        model_t r;
        int frame_len;
        r = m;
        frame_len = div * 2 * slot;
        if (!rst_n) begin
            r.active = 0; r.pend = 0; r.first = 0; r.t = 0; r.fc = 0;
        end else if (!m.active) begin
            if (en) begin
                r.active = 1; r.pend = 0; r.first = 1; r.t = 0;
            end
        end else begin
            if ((m.t % frame_len) == frame_len - 1) begin
                r.fc = (m.fc + 1) % (1 << fw);
                if (m.pend && !en) begin
                    r.active = 0; r.pend = 0; r.first = 0; r.t = 0;
                    return r;
                end
            end
            r.t = m.t + 1;
            r.pend = !en;
            r.first = 0;
        end
        return r;
    endfunction

    function automatic obs_t model_out(model_t m, int div, int slot);
        obs_t o;
        int d;
        int b;
        o = '0;
        o.fc = 16'(m.fc);
        if (m.active) begin
            d = m.t % div;
            b = (m.t / div) % (2 * slot);
            o.sck  = (d >= div / 2);
            o.ws   = (b >= slot);
            o.rise = (d == div / 2);
            o.fall = (d == 0) && !m.first;
            o.fs   = (d == 0) && (b == 0);
            o.run  = 1'b1;
            o.bidx = 8'(b);
        end
        return o;
    endfunction

    task automatic scoreboard();
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            m1 = model_step(m1, rstn, en1, DIV1, SLOT1, FW1);
            m2 = model_step(m2, rstn, en2, DIV2, SLOT2, FW2);
            @(negedge clk);
            e = model_out(m1, DIV1, SLOT1);
            a = {sck1, ws1, rise1, fall1, fs1, run1, 8'(bidx1), 16'(fc1)};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("[TB] FAIL model_dut1 t=%0t actual=%h required=%h", $time, a, e);
            end
            e = model_out(m2, DIV2, SLOT2);
            a = {sck2, ws2, rise2, fall2, fs2, run2, 8'(bidx2), 16'(fc2)};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("[TB] FAIL model_dut2 t=%0t actual=%h required=%h", $time, a, e);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sck1, ws1, rise1, fall1, fs1, run1} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs actual=%b required=000000", {sck1, ws1, rise1, fall1, fs1, run1});
        end
        n_checks++;
        if (bidx1 !== '0 || fc1 !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_counters actual=%0d/%0d required=0/0", bidx1, fc1);
        end
        en1 = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (run1 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_dominates actual=%b required=0", run1);
        end
    endtask

    task automatic test_frame_timing();
        int k;
        int nrise, nfall, nfs, mis, hi;
        logic prev_ws;
        rstn = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (run1 !== 1'b1 && k < 10);
        n_checks++;
        if (k != 1) begin
            n_fail++;
            $display("[TB] FAIL start_latency actual=%0d required=1", k);
        end
        n_checks++;
        if ({fs1, fall1, sck1, ws1} !== 4'b1000 || bidx1 !== '0) begin
            n_fail++;
            $display("[TB] FAIL first_run_cycle actual=%b/%0d required=1000/0", {fs1, fall1, sck1, ws1}, bidx1);
        end
        nrise = 0; nfall = 0; nfs = 0; mis = 0; hi = 0;
        prev_ws = 1'b0;
        for (int i = 0; i < FRAME1; i++) begin
            if (rise1 === 1'b1) nrise++;
            if (fall1 === 1'b1) nfall++;
            if (fs1 === 1'b1) nfs++;
            if (sck1 === 1'b1) hi++;
            if (ws1 !== prev_ws && fall1 !== 1'b1) mis++;
            prev_ws = ws1;
            @(negedge clk);
        end
        n_checks++;
        if (nrise != 2 * SLOT1) begin
            n_fail++;
            $display("[TB] FAIL rise_count actual=%0d required=%0d", nrise, 2 * SLOT1);
        end
        n_checks++;
        if (nfall != 2 * SLOT1 - 1) begin
            n_fail++;
            $display("[TB] FAIL fall_count actual=%0d required=%0d", nfall, 2 * SLOT1 - 1);
        end
        n_checks++;
        if (nfs != 1 || hi != FRAME1 / 2) begin
            n_fail++;
            $display("[TB] FAIL fs_and_high actual=%0d/%0d required=1/%0d", nfs, hi, FRAME1 / 2);
        end
        n_checks++;
        if (mis != 0) begin
            n_fail++;
            $display("[TB] FAIL ws_alignment actual=%0d required=0", mis);
        end
        n_checks++;
        if (fc1 !== 16'd1 || fs1 !== 1'b1 || fall1 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL second_frame actual=%0d/%b/%b required=1/1/1", fc1, fs1, fall1);
        end
    endtask

    task automatic test_drain_stop();
        int k;
        int run_cyc;
        int last_bit;
        k = 0;
        while (!(fc1 == 3 && bidx1 == 10) && k < 3 * FRAME1) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= 3 * FRAME1) begin
            n_fail++;
            $display("[TB] FAIL drain_wait_timeout actual=%0d required<%0d", k, 3 * FRAME1);
            return;
        end
        en1 = 1'b0;
        run_cyc = 0;
        last_bit = -1;
        for (int i = 0; i < 2 * FRAME1; i++) begin
            @(negedge clk);
            if (run1 !== 1'b1) break;
            run_cyc++;
            last_bit = int'(bidx1);
        end
        n_checks++;
        if (run_cyc != (2 * SLOT1 - 10) * DIV1 - 1) begin
            n_fail++;
            $display("[TB] FAIL drain_length actual=%0d required=%0d", run_cyc, (2 * SLOT1 - 10) * DIV1 - 1);
        end
        n_checks++;
        if (last_bit != 2 * SLOT1 - 1) begin
            n_fail++;
            $display("[TB] FAIL drain_last_bit actual=%0d required=%0d", last_bit, 2 * SLOT1 - 1);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (fc1 !== 16'd4 || {run1, sck1, ws1} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL idle_after_drain actual=%0d/%b required=4/000", fc1, {run1, sck1, ws1});
        end
    endtask

    task automatic test_reenable();
        int k;
        int gaps;
        int cyc;
        en1 = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (run1 !== 1'b1 && k < 5);
        n_checks++;
        if (run1 !== 1'b1 || fs1 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL restart actual=%b/%b required=1/1", run1, fs1);
        end
        k = 0;
        while (bidx1 != 10 && k < FRAME1) begin
            @(negedge clk);
            k++;
        end
        en1 = 1'b0;
        gaps = 0;
        cyc = 0;
        while (bidx1 != 40 && cyc < FRAME1) begin
            @(negedge clk);
            cyc++;
            if (run1 !== 1'b1) gaps++;
        end
        en1 = 1'b1;
        while (fs1 !== 1'b1 && cyc < 2 * FRAME1) begin
            @(negedge clk);
            cyc++;
            if (run1 !== 1'b1) gaps++;
        end
        n_checks++;
        if (gaps != 0) begin
            n_fail++;
            $display("[TB] FAIL reenable_gaps actual=%0d required=0", gaps);
        end
        n_checks++;
        if (cyc != (2 * SLOT1 - 10) * DIV1) begin
            n_fail++;
            $display("[TB] FAIL reenable_frame_start actual=%0d required=%0d", cyc, (2 * SLOT1 - 10) * DIV1);
        end
        n_checks++;
        if (bidx1 !== '0 || fc1 !== 16'd5) begin
            n_fail++;
            $display("[TB] FAIL reenable_counters actual=%0d/%0d required=0/5", bidx1, fc1);
        end
    endtask

    task automatic test_glitch();
        int k;
        int gaps;
        int cyc;
        k = 0;
        while (bidx1 != 5 && k < FRAME1) begin
            @(negedge clk);
            k++;
        end
        en1 = 1'b0;
        @(negedge clk);
        en1 = 1'b1;
        cyc = 1;
        gaps = (run1 !== 1'b1) ? 1 : 0;
        while (fs1 !== 1'b1 && cyc < 2 * FRAME1) begin
            @(negedge clk);
            cyc++;
            if (run1 !== 1'b1) gaps++;
        end
        n_checks++;
        if (gaps != 0 || cyc != (2 * SLOT1 - 5) * DIV1) begin
            n_fail++;
            $display("[TB] FAIL glitch actual=%0d gaps/%0d cycles required=0/%0d", gaps, cyc, (2 * SLOT1 - 5) * DIV1);
        end
        n_checks++;
        if (fc1 !== 16'd6) begin
            n_fail++;
            $display("[TB] FAIL glitch_frame_count actual=%0d required=6", fc1);
        end
    endtask

    task automatic test_reset_midframe();
        int k;
        k = 0;
        while (bidx1 != 20 && k < FRAME1) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (ws1 !== 1'b0 || run1 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midframe_precondition actual=%b/%b required=0/1", ws1, run1);
        end
        rstn = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({sck1, ws1, rise1, fall1, fs1, run1} !== 6'b0 || bidx1 !== '0 || fc1 !== '0) begin
            n_fail++;
            $display("[TB] FAIL midframe_reset actual=%b/%0d/%0d required=000000/0/0", {sck1, ws1, rise1, fall1, fs1, run1}, bidx1, fc1);
        end
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({run1, fs1, fall1} !== 3'b110) begin
            n_fail++;
            $display("[TB] FAIL restart_after_reset actual=%b required=110", {run1, fs1, fall1});
        end
    endtask

    task automatic test_small_config();
        int k;
        int tog_err, alt_err, ws_err;
        int fc_at48;
        logic prev_sck;
        en2 = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (run2 !== 1'b1 && k < 5);
        tog_err = 0; alt_err = 0; ws_err = 0; fc_at48 = -1;
        prev_sck = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0 && sck2 === prev_sck) tog_err++;
            if (i > 0 && (rise2 ^ fall2) !== 1'b1) alt_err++;
            if (ws2 !== ((i % 16) >= 8)) ws_err++;
            if (i == 48) fc_at48 = int'(fc2);
            prev_sck = sck2;
            @(negedge clk);
        end
        n_checks++;
        if (tog_err != 0 || alt_err != 0) begin
            n_fail++;
            $display("[TB] FAIL small_toggle actual=%0d/%0d required=0/0", tog_err, alt_err);
        end
        n_checks++;
        if (ws_err != 0) begin
            n_fail++;
            $display("[TB] FAIL small_ws_period actual=%0d required=0", ws_err);
        end
        n_checks++;
        if (fc_at48 != 3 || fc2 !== 2'd0 || fs2 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL small_fc_wrap actual=%0d/%0d/%b required=3/0/1", fc_at48, fc2, fs2);
        end
        en2 = 1'b0;
        k = 0;
        while (run2 === 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (run2 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL small_stop actual=%b required=0", run2);
        end
    endtask

    task automatic test_random();
        int k;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rstn = ($urandom_range(0, 799) != 0);
            if ($urandom_range(0, 39) == 0) en1 = ~en1;
            if ($urandom_range(0, 59) == 0) en2 = ~en2;
        end
        @(negedge clk);
        rstn = 1'b1;
        en1 = 1'b0;
        en2 = 1'b0;
        k = 0;
        while ((run1 === 1'b1 || run2 === 1'b1) && k < 2 * FRAME1 + 10) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (run1 !== 1'b0 || run2 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL random_final_stop actual=%b%b required=00", run1, run2);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        en1 = 1'b0;
        en2 = 1'b0;
        fork
            scoreboard();
        join_none
        $display("[TB] starting i2s_clock_ctrl bench");
        test_reset();
        test_frame_timing();
        test_drain_stop();
        test_reenable();
        test_glitch();
        test_reset_midframe();
        test_small_config();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
